// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, start request, 8 data + odd parity + stop, device ACK check.
// Optional device watchdog under PS2_TX_TIMEOUT_EN; send_cmd is ignored while busy and in the done/error pulse cycle.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int TIMEOUT_CYCLES = 375000
) (
   input  logic       i_clock,
   input  logic       i_resetn,
   input  logic       i_send_cmd,
   input  logic [7:0] i_cmd_data,
   input  logic       i_ps2_clock_in,
   input  logic       i_ps2_data_in,
   output logic       o_ps2_clock_oe,
   output logic       o_ps2_data_oe,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
   } state_t;

   localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [INH_W-1:0] r_cnt, w_cnt_nxt;
   logic [7:0]       r_cmd, w_cmd_nxt;
   logic             r_par, w_par_nxt;
   logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic             r_clock_oe, w_clock_oe_nxt;
   logic             r_data_oe, w_data_oe_nxt;
   logic             r_done, w_done_nxt;
   logic             r_error, w_error_nxt;

   logic r_clk_s1, r_clk_s2, r_clk_d;
   logic r_dat_s1, r_dat_s2;
   logic w_fall;
   logic w_timeout;

   // Idle bus level is high, so synchronizers reset to 1 to avoid a false edge.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_clk_d  <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= i_ps2_clock_in;
         r_clk_s2 <= r_clk_s1;
         r_clk_d  <= r_clk_s2;
         r_dat_s1 <= i_ps2_data_in;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign w_fall = r_clk_d & ~r_clk_s2;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] r_wd;
   logic            w_wd_watch;

   assign w_wd_watch = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
   assign w_timeout  = w_wd_watch && !w_fall && (r_wd == WD_LAST);

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn)                 r_wd <= '0;
      else if (!w_wd_watch || w_fall) r_wd <= '0;
      else                           r_wd <= r_wd + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_cmd      <= '0;
         r_par      <= 1'b0;
         r_bit_cnt  <= '0;
         r_clock_oe <= 1'b0;
         r_data_oe  <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_cmd      <= w_cmd_nxt;
         r_par      <= w_par_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_clock_oe <= w_clock_oe_nxt;
         r_data_oe  <= w_data_oe_nxt;
         r_done     <= w_done_nxt;
         r_error    <= w_error_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_cmd_nxt      = r_cmd;
      w_par_nxt      = r_par;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_clock_oe_nxt = r_clock_oe;
      w_data_oe_nxt  = r_data_oe;
      w_done_nxt     = 1'b0;
      w_error_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clock_oe_nxt = 1'b0;
            w_data_oe_nxt  = 1'b0;
            // The pulse cycle still counts as the tail of the previous frame.
            if (i_send_cmd && !r_done && !r_error) begin
               w_state_nxt    = S_INHIBIT;
               w_cmd_nxt      = i_cmd_data;
               w_par_nxt      = ~^i_cmd_data;
               w_bit_cnt_nxt  = '0;
               w_cnt_nxt      = '0;
               w_clock_oe_nxt = 1'b1;
            end
         end
         S_INHIBIT: begin
            if (r_cnt == INH_LAST) begin
               w_state_nxt   = S_REQ;
               w_data_oe_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_REQ: begin
            w_state_nxt    = S_SHIFT;
            w_clock_oe_nxt = 1'b0;
         end
         S_SHIFT: begin
            if (w_fall) begin
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
               if (r_bit_cnt < 4'd8) begin
                  w_data_oe_nxt = ~r_cmd[r_bit_cnt[2:0]];
               end else if (r_bit_cnt == 4'd8) begin
                  w_data_oe_nxt = ~r_par;
               end else begin
                  w_data_oe_nxt = 1'b0;
                  w_state_nxt   = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (w_fall) begin
               if (!r_dat_s2) begin
                  w_state_nxt = S_WAIT_IDLE;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_error_nxt = 1'b1;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (r_clk_s2 && r_dat_s2) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_clock_oe_nxt = 1'b0;
            w_data_oe_nxt  = 1'b0;
         end
      endcase
      if (w_timeout) begin
         w_state_nxt    = S_IDLE;
         w_clock_oe_nxt = 1'b0;
         w_data_oe_nxt  = 1'b0;
         w_done_nxt     = 1'b0;
         w_error_nxt    = 1'b1;
      end
   end

   assign o_ps2_clock_oe = r_clock_oe;
   assign o_ps2_data_oe  = r_data_oe;
   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = r_done;
   assign o_error        = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model clocks one edge per 40 cycles and checks each frame bit against a parity/LSB-first model.
module tb_ps2_host_tx;

   localparam int INH = 8;
   localparam int TMO = 200;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       send = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       pin_clk, pin_dat;
   logic       clock_oe, data_oe, busy, done, error;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Open-drain wired-AND of host and device drivers.
   assign pin_clk = dev_clk & ~clock_oe;
   assign pin_dat = dev_dat & ~data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clock        (clk),
      .i_resetn       (rstn),
      .i_send_cmd     (send),
      .i_cmd_data     (cmd),
      .i_ps2_clock_in (pin_clk),
      .i_ps2_data_in  (pin_dat),
      .o_ps2_clock_oe (clock_oe),
      .o_ps2_data_oe  (data_oe),
      .o_busy         (busy),
      .o_done         (done),
      .o_error        (error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Expected data_oe after device edges 1..10: inverted data LSB first, inverted odd parity, released stop.
   function automatic logic [10:1] frame_model(input logic [7:0] b);
      logic [10:1] r;
      int ones;
      ones = $countones(b);
      for (int i = 1; i <= 8; i++) r[i] = !b[i-1];
      r[9]  = (ones % 2 == 0) ? 1'b0 : 1'b1;
      r[10] = 1'b0;
      return r;
   endfunction

   task automatic start_frame(input logic [7:0] b);
      @(negedge clk);
      send = 1'b1;
      cmd  = b;
      @(negedge clk);
      send = 1'b0;
      cmd  = 8'($urandom);
      for (int k = 1; k <= INH + 2; k++) begin
         if (k > 1) @(negedge clk);
         check("start_clock_oe", 32'(clock_oe), 32'(k <= INH + 1));
         check("start_data_oe", 32'(data_oe), 32'(k >= INH + 1));
         check("start_busy", 32'(busy), 32'd1);
      end
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input bit inject, input int abort_edge);
      logic [10:1] want;
      int n_done, n_err;
      bit probe, probed;
      want = frame_model(b);
      start_frame(b);
      repeat (5) @(negedge clk);
      for (int e = 1; e <= 10; e++) begin
         dev_clk = 1'b0;
         repeat (10) @(negedge clk);
         if (e == abort_edge) begin
            rstn = 1'b0;
            #1;
            check("abort_clock_oe", 32'(clock_oe), 32'd0);
            check("abort_data_oe", 32'(data_oe), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            dev_clk = 1'b1;
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            n_done = 0;
            n_err  = 0;
            repeat (50) begin
               @(negedge clk);
               n_done += int'(done);
               n_err  += int'(error);
            end
            check("abort_no_pulse", 32'(n_done + n_err), 32'd0);
            return;
         end
         if (inject && e == 3) begin
            send = 1'b1;
            cmd  = 8'h12;
         end
         @(negedge clk);
         send = 1'b0;
         repeat (9) @(negedge clk);
         dev_clk = 1'b1;
         repeat (19) @(negedge clk);
         check($sformatf("bit%0d_%02h", e, b), 32'(data_oe), 32'(want[e]));
         @(negedge clk);
      end
      dev_dat = ack ? 1'b0 : 1'b1;
      @(negedge clk);
      dev_clk = 1'b0;
      n_done = 0;
      n_err  = 0;
      probe  = 1'b0;
      probed = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (c == 20) begin
            dev_clk = 1'b1;
            dev_dat = 1'b1;
         end
         if (probe) begin
            check("send_in_pulse_ignored", 32'(busy), 32'd0);
            send  = 1'b0;
            probe = 1'b0;
         end
         if (done && error) check("done_error_both", 32'd1, 32'd0);
         n_done += int'(done);
         n_err  += int'(error);
         if ((done || error) && !probed) begin
            check("busy_at_pulse", 32'(busy), 32'd0);
            send   = 1'b1;
            cmd    = 8'hAA;
            probe  = 1'b1;
            probed = 1'b1;
         end
      end
      check("done_count", 32'(n_done), 32'(ack));
      check("error_count", 32'(n_err), 32'(!ack));
      check("end_busy", 32'(busy), 32'd0);
      check("end_oe", {30'd0, clock_oe, data_oe}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_oe", {30'd0, clock_oe, data_oe}, 32'd0);
      check("rst_flags", {29'd0, busy, done, error}, 32'd0);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);

      run_frame(8'hED, 1'b1, 1'b0, 0);
      run_frame(8'h00, 1'b1, 1'b0, 0);
      run_frame(8'hFF, 1'b0, 1'b0, 0);
      run_frame(8'hED, 1'b1, 1'b1, 0);
      repeat (4) run_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 0);
      run_frame(8'hED, 1'b1, 1'b0, 5);
      run_frame(8'hF4, 1'b1, 1'b0, 0);

      begin : timeout_case
         int first_err;
         first_err = -1;
         start_frame(8'h5A);
         for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (error && first_err < 0) first_err = k;
`ifdef PS2_TX_TIMEOUT_EN
            if (first_err >= 0) break;
`endif
         end
`ifdef PS2_TX_TIMEOUT_EN
         check("timeout_latency", 32'(first_err), 32'(TMO));
         check("timeout_oe", {30'd0, clock_oe, data_oe}, 32'd0);
         check("timeout_busy", 32'(busy), 32'd0);
`else
         check("no_watchdog_error", 32'(first_err), 32'hFFFF_FFFF);
         check("no_watchdog_busy", 32'(busy), 32'd1);
         rstn = 1'b0;
         repeat (2) @(negedge clk);
         rstn = 1'b1;
         @(negedge clk);
         check("recover_busy", 32'(busy), 32'd0);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-drain ps2_clock/ps2_data lines. It is the counterpart to the existing PS/2 receive path: it sits beside the keyboard controller on the 25 MHz system clock. Top level ties each line with `assign line = oe ? 1'b0 : 1'bz` and feeds the raw pin back in.

## Interface
Parameters:
- INHIBIT_CYCLES, 2500, clock-low inhibit time in cycles (100 us at 25 MHz)
- TIMEOUT_CYCLES, 375000, max cycles waiting for any device edge (15 ms)

Ports:
- clock  input  1  system clock, 25 MHz
- resetn  input  1  reset; one clock; reset is asynchronous and active-low
- send_cmd  input  1  request strobe; sampled high while idle starts a frame
- cmd_data  input  8  command byte, latched on accept
- ps2_clock_in  input  1  raw ps2_clock pin
- ps2_data_in  input  1  raw ps2_data pin
- ps2_clock_oe  output  1  1 = drive ps2_clock low, 0 = release
- ps2_data_oe  output  1  1 = drive ps2_data low, 0 = release
- busy  output  1  high from accept until done/error
- done  output  1  one-cycle pulse: frame acknowledged
- error  output  1  one-cycle pulse: no ACK or timeout

## Operation
- Inputs pass through 2-flop synchronizers; falling edge = sync'd clock 1→0 (2-3 cycle pin latency).
- States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
- IDLE: oe both 0. send_cmd=1 → latch cmd_data, compute odd parity p = ~^cmd_data, bit_cnt=0, → INHIBIT. send_cmd in any other state is ignored.
- INHIBIT: clock_oe=1, data_oe=0, for exactly INHIBIT_CYCLES cycles → REQ.
- REQ: clock_oe=1, data_oe=1 (start bit) for 1 cycle → SHIFT.
- SHIFT: clock_oe=0 (released). On each device falling edge, bit_cnt increments and data_oe updates the next cycle: edges 1-8 → data_oe = ~cmd[edge-1] (LSB first); edge 9 → data_oe = ~p; edge 10 → data_oe=0 (stop, released) → ACK.
- ACK: on next falling edge sample sync'd data: 0 → WAIT_IDLE; 1 → error pulse, → IDLE.
- WAIT_IDLE: when sync'd clock and data both 1 → done pulse, → IDLE.
- busy = (state != IDLE); deasserts same cycle done/error pulses.
- done and error never both high.

## Timing
- Reset values: ps2_clock_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, state IDLE; resetn low releases both lines immediately (async), aborting any frame with no done/error.
- Accept at edge N → busy=1 and clock_oe=1 from N+1; clock_oe held INHIBIT_CYCLES cycles, then REQ 1 cycle (both oe), SHIFT from N+INHIBIT_CYCLES+2.
- oe outputs are registered; no combinational path from pins to outputs.
- send_cmd high the same cycle done/error pulses is ignored (FSM not yet IDLE); next accept earliest one cycle later.
- Glitch-free outputs: each oe changes at most once per cycle, only at state/bit boundaries.

## Configuration
- PS2_TX_TIMEOUT_EN defined: watchdog counter reloads to 0 on entering SHIFT/ACK/WAIT_IDLE and on every falling edge; reaching TIMEOUT_CYCLES in those states → both oe=0, error pulse, → IDLE.
- Not defined: no watchdog; SHIFT/ACK/WAIT_IDLE wait indefinitely (only resetn recovers a dead device); counter logic absent.

## Test plan
Bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model clocking at 1 edge per 40 cycles.
- send_cmd with 0xED, model ACKs → clock_oe high 8 cycles then REQ; data_oe after edges 1-10 = 0,1,0,0,1,0,0,0,0(p=1),0; done pulse once lines idle, error=0, busy low.
- send 0x00, model ACKs → data_oe=1 for edges 1-8, parity bit p=1 so data_oe=0 at edge 9; done pulse.
- send 0xFF, model holds data high at ACK edge → error pulse, done=0, both oe=0, IDLE.
- PS2_TX_TIMEOUT_EN on, model silent after REQ → error exactly 200 cycles after SHIFT entry, both oe=0; macro off → busy stays 1 after 1000 cycles.
- Assert send_cmd=1 with 0x12 during SHIFT of 0xED → ignored, frame bits remain 0xED.
- Drop resetn at edge 5 of frame → both oe=0 and busy=0 immediately; after release, new send 0xF4 completes with done.
